mp_add_sub_seq: RTL and testbench

//  Multi-precision add/subtract sequencer placed directly upstream of the registered 32-bit add/sub stage.

---
 rtl/add_sub_pkg.sv | 5 +
 rtl/mp_add_sub_seq_if.sv | 32 +++
 rtl/mp_add_sub_seq.sv | 124 ++++++++++++
 tb/tb_mp_add_sub_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// Shared word width and sequencer state encoding for the multi-precision add/sub sequencer.
package add_sub_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} mp_state_t;
endpackage

// File: rtl/mp_add_sub_seq_if.sv
// Request, word-stage and result signals of the multi-precision add/sub sequencer.
interface mp_add_sub_seq_if
  import add_sub_pkg::*;
#(parameter int NWORDS = 4);
  logic                     in_valid;
  logic                     in_ready;
  logic [NWORDS*WORD_W-1:0] in_a;
  logic [NWORDS*WORD_W-1:0] in_b;
  logic                     in_ci;
  logic                     in_sub;
  logic [WORD_W-1:0]        as_a;
  logic [WORD_W-1:0]        as_b;
  logic                     as_ci;
  logic                     as_sub;
  logic [WORD_W-1:0]        as_s;
  logic                     as_co;
  logic                     out_valid;
  logic                     out_ready;
  logic [NWORDS*WORD_W-1:0] out_res;
  logic                     out_co;
  logic                     out_zero;
  logic                     out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_ci, in_sub, as_s, as_co, out_ready,
    output in_ready, as_a, as_b, as_ci, as_sub, out_valid, out_res, out_co, out_zero, out_ovf
  );
  modport master (
    output in_valid, in_a, in_b, in_ci, in_sub, as_s, as_co, out_ready,
    input  in_ready, as_a, as_b, as_ci, as_sub, out_valid, out_res, out_co, out_zero, out_ovf
  );
endinterface

// File: rtl/mp_add_sub_seq.sv
// Multi-precision add/sub sequencer: walks NWORDS words LSW first through an external 1-cycle stage.
// Optional result flags (out_zero, out_ovf) are built when ADD_SUB_FLAGS_EN is defined.
module mp_add_sub_seq
  import add_sub_pkg::*;
#(parameter int NWORDS = 4)
(
  input logic             clk,
  input logic             rst_n,
  mp_add_sub_seq_if.slave bus
);
  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NWORDS - 1);

  mp_state_t                     r_state, w_state_nx;
  logic [IDX_W-1:0]              r_idx;
  logic [IDX_W-1:0]              w_idx_nx;
  logic [NWORDS-1:0][WORD_W-1:0] r_a, r_b, r_res;
  logic [NWORDS-1:0][WORD_W-1:0] w_res_nx;
  logic                          r_sub, r_carry;
  logic [WORD_W-1:0]             r_as_a, r_as_b;
  logic                          r_as_ci, r_as_sub;
  logic                          w_accept, w_capture, w_last;

  assign w_accept  = (r_state == IDLE) && bus.in_valid;
  assign w_capture = (r_state == WAIT);
  assign w_last    = (r_idx == LAST);
  assign w_idx_nx  = r_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_state_nx = ISSUE;
      ISSUE:   w_state_nx = WAIT;
      WAIT:    w_state_nx = w_last ? DONE : ISSUE;
      DONE:    if (bus.out_ready) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_comb begin
    w_res_nx        = r_res;
    w_res_nx[r_idx] = bus.as_s;
  end

  // Stage inputs are registered and loaded on the edge entering ISSUE, so they hold elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_as_a   <= '0;
      r_as_b   <= '0;
      r_as_ci  <= 1'b0;
      r_as_sub <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a      <= bus.in_a;
        r_b      <= bus.in_b;
        r_sub    <= bus.in_sub;
        r_carry  <= bus.in_ci;
        r_idx    <= '0;
        r_as_a   <= bus.in_a[WORD_W-1:0];
        r_as_b   <= bus.in_b[WORD_W-1:0];
        r_as_ci  <= bus.in_ci;
        r_as_sub <= bus.in_sub;
      end
      if (w_capture) begin
        r_res   <= w_res_nx;
        r_carry <= bus.as_co;
        if (!w_last) begin
          r_idx   <= w_idx_nx;
          r_as_a  <= r_a[w_idx_nx];
          r_as_b  <= r_b[w_idx_nx];
          r_as_ci <= bus.as_co;
        end
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_res   = r_res;
  assign bus.out_co    = r_carry;
  assign bus.as_a      = r_as_a;
  assign bus.as_b      = r_as_b;
  assign bus.as_ci     = r_as_ci;
  assign bus.as_sub    = r_as_sub;

`ifdef ADD_SUB_FLAGS_EN
  logic r_zero, r_ovf;
  logic w_a_msb, w_b_msb, w_s_msb;

  assign w_a_msb = r_a[NWORDS-1][WORD_W-1];
  assign w_b_msb = r_b[NWORDS-1][WORD_W-1];
  assign w_s_msb = bus.as_s[WORD_W-1];

  // Flags are taken from the final word as it lands, so they align with out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_capture && w_last) begin
      r_zero <= (w_res_nx == '0);
      r_ovf  <= r_sub ? ((w_a_msb != w_b_msb) && (w_s_msb != w_a_msb))
                      : ((w_a_msb == w_b_msb) && (w_s_msb != w_a_msb));
    end
  end

  assign bus.out_zero = r_zero;
  assign bus.out_ovf  = r_ovf;
`else
  assign bus.out_zero = 1'b0;
  assign bus.out_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_mp_add_sub_seq.sv
// Scoreboard bench for mp_add_sub_seq (NWORDS=4) with a behavioural registered 32-bit add/sub stage.
module tb_mp_add_sub_seq;
  logic clk;
  logic rst_n;

  mp_add_sub_seq_if #(.NWORDS(4)) bus();

  mp_add_sub_seq #(.NWORDS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered add/sub stage: S = A+B+Ci or A-B-Ci, Co = carry / borrow.
  logic [32:0] st_add, st_sub;
  assign st_add = {1'b0, bus.as_a} + {1'b0, bus.as_b} + {32'd0, bus.as_ci};
  assign st_sub = {1'b0, bus.as_a} - {1'b0, bus.as_b} - {32'd0, bus.as_ci};
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.as_s  <= '0;
      bus.as_co <= 1'b0;
    end else begin
      bus.as_s  <= bus.as_sub ? st_sub[31:0] : st_add[31:0];
      bus.as_co <= bus.as_sub ? st_sub[32]   : st_add[32];
    end
  end

  typedef struct {
    logic [127:0] res;
    logic         co;
    logic         zero;
    logic         ovf;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  // Whole-width arithmetic reference: unsigned for result/carry, signed range check for overflow.
  function automatic exp_t model(input logic [127:0] a, input logic [127:0] b,
                                 input logic ci, input logic sub);
    exp_t e;
    logic [128:0] u;
    logic signed [129:0] s, sa, sb, sc;
    sa = $signed({{2{a[127]}}, a});
    sb = $signed({{2{b[127]}}, b});
    sc = $signed({129'd0, ci});
    if (sub) begin
      u = {1'b0, a} - {1'b0, b} - {128'd0, ci};
      s = sa - sb - sc;
    end else begin
      u = {1'b0, a} + {1'b0, b} + {128'd0, ci};
      s = sa + sb + sc;
    end
    e.res = u[127:0];
    e.co  = u[128];
`ifdef ADD_SUB_FLAGS_EN
    e.zero = (u[127:0] == 128'd0);
    e.ovf  = (s != $signed({{2{u[127]}}, u[127:0]}));
`else
    e.zero = 1'b0;
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        timeout("unexpected_result");
      end else begin
        mon_e = q.pop_front();
        chk("res",  bus.out_res,          mon_e.res);
        chk("co",   128'(bus.out_co),     128'(mon_e.co));
        chk("zero", 128'(bus.out_zero),   128'(mon_e.zero));
        chk("ovf",  128'(bus.out_ovf),    128'(mon_e.ovf));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [127:0] a, input logic [127:0] b, input logic ci, input logic sub);
    int g = 0;
    while (!bus.in_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 100) timeout("send_wait_ready");
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_ci    = ci;
    bus.in_sub   = sub;
    @(posedge clk); #1;
    q.push_back(model(a, b, ci, sub));
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() != 0 && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 300) begin
      timeout("drain");
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  logic [127:0] c1_a, ones, y_a, ra, rb;
  exp_t held;
  int   n;

  initial begin
    c1_a = 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF;
    ones = '1;
    y_a  = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_ci = 1'b0; bus.in_sub = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  128'(bus.in_ready),  128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_res",   bus.out_res,         128'(0));
    chk("rst_out_co",    128'(bus.out_co),    128'(0));
    chk("rst_out_zero",  128'(bus.out_zero),  128'(0));
    chk("rst_out_ovf",   128'(bus.out_ovf),   128'(0));
    chk("rst_as_a",      128'(bus.as_a),      128'(0));
    chk("rst_as_b",      128'(bus.as_b),      128'(0));
    chk("rst_as_ci",     128'(bus.as_ci),     128'(0));
    chk("rst_as_sub",    128'(bus.as_sub),    128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Carry ripple across words, plus accept-to-valid latency.
    send(c1_a, 128'd1, 1'b0, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 128'(n), 128'(8));
    drain();

    send(128'd0, 128'd1, 1'b0, 1'b1);           // borrow ripple
    drain();
    send(ones, 128'd0, 1'b1, 1'b0);             // full wrap to zero
    drain();
    send({1'b0, {127{1'b1}}}, 128'd1, 1'b0, 1'b0); // signed overflow
    drain();

    // Backpressure with a competing request held during the stall.
    bus.out_ready = 1'b0;
    send(128'h8000_0000_0000_0000_0000_0000_0000_0005, 128'd7, 1'b1, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) timeout("bp_wait_valid");
    held = q[0];
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        bus.in_valid = 1'b1; bus.in_a = y_a; bus.in_b = ones; bus.in_ci = 1'b0; bus.in_sub = 1'b0;
      end
      chk("bp_valid",    128'(bus.out_valid), 128'(1));
      chk("bp_res",      bus.out_res,         held.res);
      chk("bp_co",       128'(bus.out_co),    128'(held.co));
      chk("bp_in_ready", 128'(bus.in_ready),  128'(0));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_ready", 128'(bus.in_ready),  128'(1));
    chk("bp_idle_valid", 128'(bus.out_valid), 128'(0));
    @(posedge clk); #1;
    chk("bp_second_acc", 128'(bus.in_ready),  128'(0));
    q.push_back(model(y_a, ones, 1'b0, 1'b0));
    bus.in_valid = 1'b0;
    drain();

    // Abort in WAIT of word 2.
    send(c1_a, 128'd1, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 128'(bus.out_valid), 128'(0));
    chk("abort_ready", 128'(bus.in_ready),  128'(1));
    chk("abort_res",   bus.out_res,         128'(0));
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(c1_a, 128'd1, 1'b0, 1'b0);
    drain();

    // Random ops, back to back, with occasional boundary operands.
    for (int i = 0; i < 30; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 5))
        0: ra = ones;
        1: rb = ones;
        2: rb = ra;
        3: ra = {1'b1, 127'd0};
        default: ;
      endcase
      send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
